// File: rtl/nvdla_csb_cfg_pkg.sv
// Shared types for the CSB configuration sequencer: command opcodes, FSM states
// and the queued command record.
package nvdla_csb_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'd0,
        OP_READ      = 2'd1,
        OP_POLL      = 2'd2,
        OP_WAIT_INTR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_GAP       = 3'd3,
        ST_WAIT_INTR = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } cmd_t;

    // A POLL read matches when every bit selected by mask equals the compare value.
    function automatic logic poll_match(input logic [31:0] rd,
                                        input logic [31:0] cmp,
                                        input logic [31:0] mask);
        return ((rd ^ cmp) & mask) == '0;
    endfunction

endpackage

// File: rtl/nvdla_csb_cmd_fifo.sv
// Command queue: FIFO_DEPTH entries of cmd_t held in flops; the head entry is
// presented from storage the cycle after it is written.
module nvdla_csb_cmd_fifo
    import nvdla_csb_cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  cmd_t wr_data,
    input  logic rd_en,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/nvdla_csb_cfg_sequencer.sv
// APB master that replays a queued WRITE/READ/POLL/WAIT_INTR command stream into
// the NVDLA apb2csb slave and returns one response per command.
module nvdla_csb_cfg_sequencer
    import nvdla_csb_cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        dla_intr
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(POLL_GAP - 1);

    state_e                 state;
    state_e                 state_nxt;
    cmd_t                   cmd_in;
    cmd_t                   fifo_dout;
    cmd_t                   cmd_q;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   intr_meta;
    logic                   intr_sync;
    logic [31:0]            rsp_data_q;
    logic                   rsp_err_q;
    logic                   poll_hit;
    logic                   tmo_last;
    logic                   gap_last;
    logic                   is_poll;

    always_comb begin
        cmd_in      = '0;
        cmd_in.op   = op_e'(cmd_op);
        cmd_in.addr = cmd_addr;
        cmd_in.data = cmd_data;
        cmd_in.mask = cmd_mask;
    end

    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    nvdla_csb_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (pclk),
        .rst     (prst),
        .wr_en   (push),
        .wr_data (cmd_in),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // dla_intr comes from another clock domain; only intr_sync is used by the FSM.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            intr_meta <= 1'b0;
            intr_sync <= 1'b0;
        end else begin
            intr_meta <= dla_intr;
            intr_sync <= intr_meta;
        end
    end

    assign is_poll  = (cmd_q.op == OP_POLL);
    assign poll_hit = poll_match(prdata, cmd_q.data, cmd_q.mask);
    assign tmo_last = (tmo_cnt == TMO_LAST);
    assign gap_last = (gap_cnt == GAP_LAST);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_nxt = (fifo_dout.op == OP_WAIT_INTR) ? ST_WAIT_INTR : ST_SETUP;
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    if (is_poll && !pslverr && !poll_hit && !tmo_last) state_nxt = ST_GAP;
                    else                                               state_nxt = ST_RESP;
                end
            end
            ST_GAP: begin
                if (gap_last) state_nxt = ST_SETUP;
            end
            ST_WAIT_INTR: begin
                if (intr_sync || tmo_last) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // tmo_cnt counts POLL read attempts or WAIT_INTR cycles; cleared on every pop.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cmd_q      <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cmd_q   <= fifo_dout;
                        tmo_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        gap_cnt    <= '0;
                        rsp_data_q <= (cmd_q.op == OP_WRITE) ? '0 : prdata;
                        rsp_err_q  <= pslverr || (is_poll && !poll_hit && tmo_last);
                        if (is_poll) tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt + 1'b1;
                ST_WAIT_INTR: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (intr_sync || tmo_last) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= !intr_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            ST_RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
        pwrite = psel && (cmd_q.op == OP_WRITE);
    end

    // Address/data come straight from cmd_q, so they stay stable for the whole transfer.
    assign paddr    = cmd_q.addr;
    assign pwdata   = (cmd_q.op == OP_WRITE) ? cmd_q.data : '0;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_nvdla_csb_cfg_sequencer.sv
// Directed bench for nvdla_csb_cfg_sequencer with a behavioural APB slave.
`timescale 1ns/1ps
module tb_nvdla_csb_cfg_sequencer;

    localparam int unsigned TMO = 16;
    localparam int unsigned GAP = 16;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        dla_intr = 1'b0;

    nvdla_csb_cfg_sequencer #(
        .FIFO_DEPTH (4),
        .POLL_GAP   (GAP),
        .TIMEOUT    (TMO),
        .TIMEOUT_W  (5)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_mask  (cmd_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .dla_intr  (dla_intr)
    );

    always #5 pclk = ~pclk;

    int unsigned cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // APB slave: wait_states low cycles of pready per transfer, read data by transfer index.
    int unsigned wait_states = 0;
    logic        slv_err = 1'b0;
    logic [31:0] rd_vals [64];
    int unsigned gap_log [64];
    int unsigned n_setup = 0;
    int unsigned n_access = 0;
    int unsigned wcnt = 0;
    int unsigned idle_run = 0;
    int unsigned stab_err = 0;
    int unsigned b2b_err = 0;
    logic [5:0]  cur_idx = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic        last_write = 1'b0;
    logic        prev_acc = 1'b0;

    always @(negedge pclk) begin
        if (psel && !penable) begin
            if (prev_acc) b2b_err <= b2b_err + 1;
            gap_log[n_setup[5:0]] <= idle_run;
            idle_run   <= 0;
            last_addr  <= paddr;
            last_write <= pwrite;
            last_wdata <= pwdata;
            cur_idx    <= n_setup[5:0];
            n_setup    <= n_setup + 1;
            wcnt       <= 0;
            pready     <= 1'b0;
        end else if (psel && penable) begin
            n_access <= n_access + 1;
            if (paddr != last_addr || pwrite != last_write || pwdata != last_wdata)
                stab_err <= stab_err + 1;
            if (wcnt >= wait_states) begin
                pready  <= 1'b1;
                prdata  <= rd_vals[cur_idx];
                pslverr <= slv_err;
            end else begin
                pready <= 1'b0;
                wcnt   <= wcnt + 1;
            end
        end else begin
            idle_run <= idle_run + 1;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end
        prev_acc <= psel && penable;
    end

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] mask,
                        output int unsigned hs);
        int unsigned n = 0;
        @(negedge pclk);
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) check("push_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        @(posedge pclk);
        #1;
        hs        = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int unsigned max_cyc, output int unsigned rc,
                           output logic [31:0] d, output logic e);
        int unsigned n = 0;
        @(negedge pclk);
        while (!rsp_valid && n < max_cyc) begin
            @(negedge pclk);
            n++;
        end
        check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
        rc = cyc;
        d  = rsp_data;
        e  = rsp_err;
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int unsigned hs, rc, base, base_a, seen;
    logic [31:0] d;
    logic        e;

    initial begin
        for (int i = 0; i < 64; i++) rd_vals[i] = '0;

        // Reset values while prst is held.
        #12;
        check("rst_psel",      {31'b0, psel},      32'd0);
        check("rst_penable",   {31'b0, penable},   32'd0);
        check("rst_pwrite",    {31'b0, pwrite},    32'd0);
        check("rst_paddr",     paddr,              32'd0);
        check("rst_pwdata",    pwdata,             32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  rsp_data,           32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy",      {31'b0, busy},      32'd0);
        @(negedge pclk);
        prst = 1'b0;
        repeat (2) @(negedge pclk);

        // WRITE, zero wait states: response 3 edges after the handshake edge.
        base = n_setup;
        push(2'd0, 32'h0000_5004, 32'hDEAD_BEEF, 32'h0, hs);
        get_rsp(20, rc, d, e);
        check("wr_latency", rc - hs, 32'd3);
        check("wr_setups",  n_setup - base, 32'd1);
        check("wr_paddr",   last_addr, 32'h0000_5004);
        check("wr_pwrite",  {31'b0, last_write}, 32'd1);
        check("wr_pwdata",  last_wdata, 32'hDEAD_BEEF);
        check("wr_data",    d, 32'd0);
        check("wr_err",     {31'b0, e}, 32'd0);

        // READ with 3 pready wait cycles -> 4 penable cycles.
        wait_states = 3;
        base   = n_setup;
        base_a = n_access;
        rd_vals[base[5:0]] = 32'h1234_5678;
        push(2'd1, 32'h0000_5008, 32'h0, 32'h0, hs);
        get_rsp(30, rc, d, e);
        check("rd_latency", rc - hs, 32'd6);
        check("rd_penable", n_access - base_a, 32'd4);
        check("rd_paddr",   last_addr, 32'h0000_5008);
        check("rd_pwrite",  {31'b0, last_write}, 32'd0);
        check("rd_data",    d, 32'h1234_5678);
        check("rd_err",     {31'b0, e}, 32'd0);
        wait_states = 0;

        // POLL mask=1 data=1, reads return 0,0,1.
        base = n_setup;
        rd_vals[base[5:0]]       = 32'h0;
        rd_vals[(base + 1) % 64] = 32'h0;
        rd_vals[(base + 2) % 64] = 32'h1;
        push(2'd2, 32'h0000_500C, 32'h1, 32'h1, hs);
        get_rsp(200, rc, d, e);
        check("poll_reads", n_setup - base, 32'd3);
        check("poll_gap1",  gap_log[(base + 1) % 64], GAP);
        check("poll_gap2",  gap_log[(base + 2) % 64], GAP);
        check("poll_data",  d, 32'h1);
        check("poll_err",   {31'b0, e}, 32'd0);

        // POLL that never matches: exactly TMO reads, then error.
        base = n_setup;
        for (int i = 0; i < 32; i++) rd_vals[(base + i) % 64] = 32'h0000_000F;
        push(2'd2, 32'h0000_5010, 32'h0000_00A0, 32'h0000_00F0, hs);
        get_rsp(1000, rc, d, e);
        check("poll_to_reads", n_setup - base, TMO);
        check("poll_to_err",   {31'b0, e}, 32'd1);
        check("poll_to_data",  d, 32'h0000_000F);

        // WRITE answered with pslverr.
        slv_err = 1'b1;
        push(2'd0, 32'h0000_5014, 32'h0000_0001, 32'h0, hs);
        get_rsp(20, rc, d, e);
        check("wr_slverr_err",  {31'b0, e}, 32'd1);
        check("wr_slverr_data", d, 32'd0);
        slv_err = 1'b0;

        // WAIT_INTR: interrupt 10 edges after pop, 2 sync edges, 1 transition edge.
        base = n_setup;
        push(2'd3, 32'h0, 32'h0, 32'h0, hs);
        fork
            begin
                repeat (11) @(posedge pclk);
                #1 dla_intr = 1'b1;
            end
            get_rsp(40, rc, d, e);
        join
        check("intr_latency", rc - hs, 32'd14);
        check("intr_psel",    n_setup - base, 32'd0);
        check("intr_err",     {31'b0, e}, 32'd0);
        check("intr_data",    d, 32'd0);
        dla_intr = 1'b0;
        repeat (4) @(negedge pclk);

        // WAIT_INTR timeout: TMO cycles in WAIT_INTR after the pop edge.
        push(2'd3, 32'h0, 32'h0, 32'h0, hs);
        get_rsp(60, rc, d, e);
        check("intr_to_latency", rc - hs, TMO + 1);
        check("intr_to_err",     {31'b0, e}, 32'd1);

        // Fill the queue behind a stalled transfer, then reset mid-ACCESS.
        wait_states = 1000;
        for (int i = 0; i < 5; i++)
            push(2'd0, 32'h0000_6000 + 32'(i * 4), 32'(i), 32'h0, hs);
        check("fill_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("fill_busy",      {31'b0, busy},      32'd1);
        @(negedge pclk);
        check("fill_psel",      {31'b0, psel},      32'd1);
        check("fill_penable",   {31'b0, penable},   32'd1);
        check("fill_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        #2 prst = 1'b1;
        #1;
        check("mid_rst_psel",      {31'b0, psel},      32'd0);
        check("mid_rst_penable",   {31'b0, penable},   32'd0);
        check("mid_rst_busy",      {31'b0, busy},      32'd0);
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        wait_states = 0;
        base = n_setup;
        @(negedge pclk);
        prst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (rsp_valid) seen++;
        end
        check("post_rst_no_rsp",  seen, 32'd0);
        check("post_rst_no_xfer", n_setup - base, 32'd0);
        check("post_rst_busy",    {31'b0, busy}, 32'd0);

        check("apb_stable",  stab_err, 32'd0);
        check("apb_b2b",     b2b_err,  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
